// File: rtl/adc_spi_responder.sv
// SPI mode-0 slave that streams a held ADC sample word out on MISO while capturing the MOSI word.
// All SPI pins are asynchronous and are resynchronised into the clk domain before edge detection.
module adc_spi_responder #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_sclk,
  input  logic                  spi_ss_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_abort,
  output logic                  underrun
);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t r_state, w_next;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_ss_sync, r_mosi_sync, r_prime;
  logic                   r_sclk_q, r_ss_q;
  logic                   r_armed, r_rdy_en, r_hold_full;
  logic [DATA_WIDTH-1:0]  r_hold, r_tx, r_rx;
  logic [CW-1:0]          r_cnt;

  logic w_sclk_s, w_ss_s, w_mosi_s, w_primed;
  logic w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;
  logic w_start, w_last, w_abort, w_accept;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  // r_prime marks when the synchroniser outputs reflect the pin rather than reset values
  assign w_primed    = r_prime[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_q;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_q;
  assign w_ss_fall   = ~w_ss_s & r_ss_q;
  assign w_ss_rise   = w_ss_s & ~r_ss_q;

  assign tx_ready    = r_rdy_en & ~r_hold_full;
  assign w_accept    = tx_valid & tx_ready;
  assign spi_miso_oe = (r_state != IDLE);
  assign spi_miso    = (r_state == SHIFT) & r_tx[DATA_WIDTH-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_prime     <= '0;
      r_sclk_q    <= 1'b0;
      r_ss_q      <= 1'b1;
      r_state     <= IDLE;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], spi_ss_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_prime     <= {r_prime[SYNC_STAGES-2:0], 1'b1};
      r_sclk_q    <= w_sclk_s;
      r_ss_q      <= w_ss_s;
      r_state     <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_last  = 1'b0;
    w_abort = 1'b0;
    case (r_state)
      IDLE: if (w_ss_fall && r_armed) begin
        w_next  = SHIFT;
        w_start = 1'b1;
      end
      SHIFT: if (w_ss_rise) begin
        w_next  = IDLE;
        w_abort = 1'b1;
      end else if (w_sclk_rise && r_cnt == CW'(DATA_WIDTH - 1)) begin
        w_next = DONE;
        w_last = 1'b1;
      end
      DONE: if (w_ss_rise) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_armed     <= 1'b0;
      r_rdy_en    <= 1'b0;
      r_hold_full <= 1'b0;
      r_hold      <= '0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_cnt       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_abort <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      r_rdy_en    <= 1'b1;
      rx_valid    <= w_last;
      frame_abort <= w_abort;
      underrun    <= w_start & ~r_hold_full;

      // SS_n must be seen high after the pipeline is primed before a frame may start
      if (w_start)
        r_armed <= 1'b0;
      else if (r_state == IDLE && w_primed && w_ss_s && r_ss_q)
        r_armed <= 1'b1;

      // a word accepted on the start cycle is held for the following frame
      if (w_accept) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end else if (w_start) begin
        r_hold_full <= 1'b0;
      end

      if (w_start) begin
        r_tx  <= r_hold_full ? r_hold : '0;
        r_rx  <= '0;
        r_cnt <= '0;
      end else if (r_state == SHIFT) begin
        if (w_sclk_rise) begin
          r_rx  <= {r_rx[DATA_WIDTH-2:0], w_mosi_s};
          r_cnt <= r_cnt + CW'(1);
        end
        if (w_sclk_fall)
          r_tx <= {r_tx[DATA_WIDTH-2:0], 1'b0};
      end

      if (w_last)
        rx_data <= {r_rx[DATA_WIDTH-2:0], w_mosi_s};
    end
  end
endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: SPI master tasks at SCLK = clk/8, hand-computed expectations.
module tb_adc_spi_responder;
  logic        clk = 1'b0, reset = 1'b1;
  logic        spi_sclk = 1'b0, spi_ss_n = 1'b1, spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe;
  logic [15:0] tx_data = 16'h0;
  logic        tx_valid = 1'b0, tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid, frame_abort, underrun;
  int          total = 0, bad = 0;
  int          n_rxv = 0, n_ab = 0, n_un = 0;

  adc_spi_responder #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_abort(frame_abort),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  // every high cycle counts, so a stretched pulse shows up as an extra event
  always @(negedge clk) begin
    if (rx_valid)    n_rxv <= n_rxv + 1;
    if (frame_abort) n_ab  <= n_ab + 1;
    if (underrun)    n_un  <= n_un + 1;
  end

  task automatic load(input logic [15:0] w);
    @(negedge clk);
    tx_data  = w;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic spi_frame(input logic [15:0] mosi_w, input int nbits, input int extra,
                           input logic inj, input logic [15:0] inj_w, input logic keep_low,
                           output logic [15:0] miso_w, output logic extra_miso,
                           output logic oe_after);
    miso_w = 16'h0; extra_miso = 1'b0; oe_after = 1'b1;
    @(negedge clk);
    spi_ss_n = 1'b0;
    if (inj) begin
      @(negedge clk); @(negedge clk);
      tx_data = inj_w; tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      #50;
    end else #80;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mosi_w[15-i];
      #40; miso_w[15-i] = spi_miso; spi_sclk = 1'b1;
      #40; spi_sclk = 1'b0;
    end
    for (int i = 0; i < extra; i++) begin
      spi_mosi = 1'b1;
      #40; extra_miso = extra_miso | spi_miso; spi_sclk = 1'b1;
      #40; spi_sclk = 1'b0;
    end
    #40;
    if (!keep_low) begin
      spi_ss_n = 1'b1;
      repeat (4) @(negedge clk);
      oe_after = spi_miso_oe;
      #80;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++; if (spi_miso_oe !== 1'b0) begin bad++; $display("FAIL rst_oe got=%b exp=0", spi_miso_oe); end
    total++; if (spi_miso !== 1'b0) begin bad++; $display("FAIL rst_miso got=%b exp=0", spi_miso); end
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL rst_tx_ready got=%b exp=0", tx_ready); end
    total++; if (rx_data !== 16'h0) begin bad++; $display("FAIL rst_rx_data got=%h exp=0000", rx_data); end
    total++; if ({rx_valid, frame_abort, underrun} !== 3'b000) begin bad++; $display("FAIL rst_pulses got=%b exp=000", {rx_valid, frame_abort, underrun}); end
    reset = 1'b0;
    @(negedge clk);
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL rel_tx_ready got=%b exp=1", tx_ready); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_basic;
    logic [15:0] m; logic e, oe; int r0, u0;
    load(16'hA5C3);
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_drop got=%b exp=0", tx_ready); end
    r0 = n_rxv; u0 = n_un;
    spi_frame(16'h1234, 16, 0, 1'b0, 16'h0, 1'b0, m, e, oe);
    total++; if (m !== 16'hA5C3) begin bad++; $display("FAIL basic_miso got=%h exp=a5c3", m); end
    total++; if (rx_data !== 16'h1234) begin bad++; $display("FAIL basic_rx_data got=%h exp=1234", rx_data); end
    total++; if (n_rxv - r0 !== 1) begin bad++; $display("FAIL basic_rx_valid got=%0d exp=1", n_rxv - r0); end
    total++; if (n_un - u0 !== 0) begin bad++; $display("FAIL basic_underrun got=%0d exp=0", n_un - u0); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_back got=%b exp=1", tx_ready); end
    total++; if (oe !== 1'b0) begin bad++; $display("FAIL basic_oe_off got=%b exp=0", oe); end
  endtask

  task automatic test_underrun;
    logic [15:0] m; logic e, oe; int r0, u0;
    r0 = n_rxv; u0 = n_un;
    spi_frame(16'hBEEF, 16, 0, 1'b0, 16'h0, 1'b0, m, e, oe);
    total++; if (m !== 16'h0000) begin bad++; $display("FAIL under_miso got=%h exp=0000", m); end
    total++; if (n_un - u0 !== 1) begin bad++; $display("FAIL under_pulse got=%0d exp=1", n_un - u0); end
    total++; if (n_rxv - r0 !== 1) begin bad++; $display("FAIL under_rx_valid got=%0d exp=1", n_rxv - r0); end
    total++; if (rx_data !== 16'hBEEF) begin bad++; $display("FAIL under_rx_data got=%h exp=beef", rx_data); end
  endtask

  task automatic test_abort;
    logic [15:0] m; logic e, oe; int r0, a0;
    r0 = n_rxv; a0 = n_ab;
    spi_frame(16'hFFFF, 7, 0, 1'b0, 16'h0, 1'b0, m, e, oe);
    total++; if (n_ab - a0 !== 1) begin bad++; $display("FAIL abort_pulse got=%0d exp=1", n_ab - a0); end
    total++; if (n_rxv - r0 !== 0) begin bad++; $display("FAIL abort_rx_valid got=%0d exp=0", n_rxv - r0); end
    total++; if (rx_data !== 16'hBEEF) begin bad++; $display("FAIL abort_rx_data got=%h exp=beef", rx_data); end
    total++; if (oe !== 1'b0) begin bad++; $display("FAIL abort_oe got=%b exp=0", oe); end
  endtask

  task automatic test_same_cycle;
    logic [15:0] m; logic e, oe; int u0, a0;
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL same_ready got=%b exp=1", tx_ready); end
    u0 = n_un;
    spi_frame(16'h5A5A, 16, 0, 1'b1, 16'h00FF, 1'b0, m, e, oe);
    total++; if (m !== 16'h0000) begin bad++; $display("FAIL same_miso1 got=%h exp=0000", m); end
    total++; if (n_un - u0 !== 1) begin bad++; $display("FAIL same_underrun got=%0d exp=1", n_un - u0); end
    u0 = n_un; a0 = n_ab;
    spi_frame(16'h3C3C, 16, 0, 1'b0, 16'h0, 1'b0, m, e, oe);
    total++; if (m !== 16'h00FF) begin bad++; $display("FAIL same_miso2 got=%h exp=00ff", m); end
    total++; if (n_un - u0 !== 0) begin bad++; $display("FAIL same_underrun2 got=%0d exp=0", n_un - u0); end
    total++; if (rx_data !== 16'h3C3C) begin bad++; $display("FAIL same_rx_data got=%h exp=3c3c", rx_data); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] m; logic e, oe; int r0, a0, u0;
    load(16'h5555);
    spi_frame(16'hAAAA, 5, 0, 1'b0, 16'h0, 1'b1, m, e, oe);
    r0 = n_rxv; a0 = n_ab; u0 = n_un;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (spi_miso_oe !== 1'b0) begin bad++; $display("FAIL rmid_oe_in_rst got=%b exp=0", spi_miso_oe); end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #40 spi_sclk = 1'b1;
      #40 spi_sclk = 1'b0;
    end
    repeat (20) @(negedge clk);
    total++; if (spi_miso_oe !== 1'b0) begin bad++; $display("FAIL rmid_no_frame got=%b exp=0", spi_miso_oe); end
    total++; if ((n_rxv - r0) + (n_ab - a0) + (n_un - u0) !== 0) begin bad++; $display("FAIL rmid_pulses got=%0d exp=0", (n_rxv - r0) + (n_ab - a0) + (n_un - u0)); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", tx_ready); end
    total++; if (rx_data !== 16'h0) begin bad++; $display("FAIL rmid_rx_data got=%h exp=0000", rx_data); end
    spi_ss_n = 1'b1;
    repeat (6) @(negedge clk);
    u0 = n_un; r0 = n_rxv;
    spi_frame(16'h0F0F, 16, 0, 1'b0, 16'h0, 1'b0, m, e, oe);
    total++; if (m !== 16'h0000) begin bad++; $display("FAIL rmid_miso got=%h exp=0000", m); end
    total++; if (n_un - u0 !== 1) begin bad++; $display("FAIL rmid_underrun got=%0d exp=1", n_un - u0); end
    total++; if (rx_data !== 16'h0F0F) begin bad++; $display("FAIL rmid_frame_rx got=%h exp=0f0f", rx_data); end
    total++; if (n_rxv - r0 !== 1) begin bad++; $display("FAIL rmid_rx_valid got=%0d exp=1", n_rxv - r0); end
  endtask

  task automatic test_extra_sclk;
    logic [15:0] m; logic e, oe; int r0;
    load(16'h8001);
    r0 = n_rxv;
    spi_frame(16'hCAFE, 16, 3, 1'b0, 16'h0, 1'b0, m, e, oe);
    total++; if (m !== 16'h8001) begin bad++; $display("FAIL extra_miso got=%h exp=8001", m); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL extra_miso_done got=%b exp=0", e); end
    total++; if (rx_data !== 16'hCAFE) begin bad++; $display("FAIL extra_rx_data got=%h exp=cafe", rx_data); end
    total++; if (n_rxv - r0 !== 1) begin bad++; $display("FAIL extra_rx_valid got=%0d exp=1", n_rxv - r0); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_underrun;
    test_abort;
    test_same_cycle;
    test_reset_mid;
    test_extra_sclk;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adc_spi_responder.md
ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, SPI frame length in bits (range 8-32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth for SPI pin inputs (range 2-3).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port spi_sclk  input  1  SPI clock from master, asynchronous to clk, CPOL=0.
REQ-006 SHALL have port spi_ss_n  input  1  active-low slave select, asynchronous.
REQ-007 SHALL have port spi_mosi  input  1  master-to-slave data, asynchronous.
REQ-008 SHALL have port spi_miso  output  1  slave-to-master data, MSB first.
REQ-009 SHALL have port spi_miso_oe  output  1  MISO output enable; 1 only while selected.
REQ-010 SHALL have port tx_data  input  DATA_WIDTH  sample word for next frame.
REQ-011 SHALL have port tx_valid  input  1  tx_data valid.
REQ-012 SHALL have port tx_ready  output  1  holding register empty.
REQ-013 SHALL have port rx_data  output  DATA_WIDTH  last complete word received on MOSI.
REQ-014 SHALL have port rx_valid  output  1  one-cycle pulse, rx_data updated.
REQ-015 SHALL have port frame_abort  output  1  one-cycle pulse, SS_n deasserted before DATA_WIDTH bits.
REQ-016 SHALL have port underrun  output  1  one-cycle pulse, frame started with holding register empty.

Function
REQ-017 SHALL pass spi_sclk, spi_ss_n, spi_mosi through SYNC_STAGES flops; edges detected by comparing synced value with its previous registered value.
REQ-018 SHALL operate SPI mode 0: capture MOSI on synced SCLK rising edge, advance MISO on synced SCLK falling edge; supported SCLK frequency <= clk/8.
REQ-019 SHALL accept tx_data into a one-word holding register on tx_valid & tx_ready; tx_ready drops next cycle and returns to 1 the cycle after the holding register is consumed.
REQ-020 SHALL implement states IDLE, SHIFT, DONE.
REQ-021 IDLE -> SHIFT on synced SS_n falling edge while armed: load tx shift register from holding register (empty it), else load all zeros and pulse underrun; bit counter = 0; spi_miso_oe = 1; spi_miso = shift MSB.
REQ-022 SHALL drive first MISO bit within SYNC_STAGES+2 clk cycles of SS_n pin falling.
REQ-023 In SHIFT, each synced SCLK rising edge SHALL shift synced MOSI into rx shift register LSB and increment bit counter; each falling edge SHALL shift tx register left, zero fill.
REQ-024 On the DATA_WIDTH-th rising edge SHALL copy rx shift register to rx_data, pulse rx_valid next cycle, enter DONE.
REQ-025 In DONE, SHALL ignore further SCLK edges and drive spi_miso = 0 with spi_miso_oe = 1.
REQ-026 On synced SS_n rising edge: from SHIFT pulse frame_abort, leave rx_data unchanged, no rx_valid; from DONE no pulse; both -> IDLE with spi_miso_oe = 0, spi_miso = 0.
REQ-027 tx_valid accepted in the same cycle as the SS_n falling-edge load SHALL NOT be used by that frame; the current holding content (or underrun) applies, new word waits for next frame.
REQ-028 SHALL re-arm only after synced SS_n observed high for >= 1 cycle; an SS_n already low at reset release SHALL NOT start a frame.
REQ-029 rx_valid, frame_abort, underrun SHALL never be high more than one consecutive cycle per event.

Reset
REQ-030 While reset is high, on each clk edge: state IDLE, disarmed, holding empty, shift registers and bit counter 0, synchronisers SS_n=1/SCLK=0/MOSI=0.
REQ-031 During reset spi_miso=0, spi_miso_oe=0, tx_ready=0, rx_data=0, rx_valid=0, frame_abort=0, underrun=0; tx_ready=1 first cycle after release.
REQ-032 Reset mid-frame SHALL abandon the frame silently (no frame_abort), discarding holding word.

Verification
REQ-033 Load 0xA5C3, frame with MOSI 0x1234, SCLK=clk/8 -> MISO bits 1010010111000011, rx_data=0x1234, one rx_valid pulse, tx_ready back to 1.
REQ-034 Frame with holding empty -> underrun pulse once, MISO all 0, rx_valid still pulses with received word.
REQ-035 SS_n rises after 7 bits -> frame_abort one pulse, rx_data keeps previous value, spi_miso_oe=0 within SYNC_STAGES+2 cycles.
REQ-036 tx_valid=1 (0x00FF) same cycle SS_n falling edge detected, holding empty -> underrun, frame sends 0x0000; next frame sends 0x00FF.
REQ-037 Reset asserted mid-frame with SS_n held low, released -> no frame, no pulses; SS_n high then low -> normal frame.
REQ-038 Extra 3 SCLK pulses after 16th bit -> rx_data unchanged, MISO=0, single rx_valid.
